filter_3x3_stream: RTL and testbench

FILTER_3X3_STREAM -- requirements
Module: filter_3x3_stream

---
 rtl/filter_3x3_stream_if.sv | 24 ++
 rtl/filter_3x3_stream.sv | 134 +++++++++++++
 tb/tb_filter_3x3_stream.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/filter_3x3_stream_if.sv
// Pixel stream bundle for filter_3x3_stream: input pixel channel (s_*) and filtered output channel (m_*).
// The filter connects through the slave modport; the source/sink side uses master.
interface filter_3x3_stream_if #(
    parameter int PIX_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             s_sof;
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_data;
    logic             m_eol;

    modport master (
        output s_valid, s_data, s_sof, m_ready,
        input  s_ready, m_valid, m_data, m_eol
    );

    modport slave (
        input  s_valid, s_data, s_sof, m_ready,
        output s_ready, m_valid, m_data, m_eol
    );
endinterface

// File: rtl/filter_3x3_stream.sv
// Streaming 3x3 convolution over row-major pixels with two line buffers and a one-deep output register.
// Define FILTER3X3_ABS_EN for edge-magnitude mode (negative results are replaced by their magnitude).
module filter_3x3_stream #(
    parameter int LINE_LEN  = 240,
    parameter int PIX_W     = 16,
    parameter int W_CORNER  = 0,
    parameter int W_EDGE    = 1,
    parameter int W_CENTER  = -4,
    parameter int DIV_SHIFT = 0
) (
    input logic                clk,
    input logic                reset,
    filter_3x3_stream_if.slave bus
);
    localparam int CW = $clog2(LINE_LEN);
    localparam int SW = PIX_W + 8;
    localparam logic [CW-1:0] LAST_COL = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] FIRST_OUT_COL = CW'(2);
    localparam logic signed [SW-1:0] K_CORNER = SW'(W_CORNER);
    localparam logic signed [SW-1:0] K_EDGE   = SW'(W_EDGE);
    localparam logic signed [SW-1:0] K_CENTER = SW'(W_CENTER);
    localparam logic signed [SW-1:0] MAX_PIX  = SW'((1 << PIX_W) - 1);

    typedef logic [PIX_W-1:0] pix_t;

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [1:0]    row_q, row_d, row_eff;
    pix_t          win_q [3][3];
    pix_t          win_d [3][3];
    pix_t          line0_mem [LINE_LEN];
    pix_t          line1_mem [LINE_LEN];
    logic          m_valid_q, m_valid_d;
    pix_t          m_data_q, m_data_d;
    logic          m_eol_q, m_eol_d;
    logic          accept, produce;
    logic signed [SW-1:0] sum, shifted, mag;
    pix_t          result;

    function automatic logic signed [SW-1:0] tap(input pix_t p, input logic signed [SW-1:0] w);
        return $signed({8'b0, p}) * w;
    endfunction

    assign bus.s_ready = !m_valid_q || bus.m_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_eol   = m_eol_q;
    assign accept      = bus.s_valid && bus.s_ready;

    // SOF forces the accepted pixel to (0,0) regardless of where the counters were.
    always_comb begin
        col_eff = bus.s_sof ? '0 : col_q;
        row_eff = bus.s_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        if (accept) begin
            if (col_eff == LAST_COL) begin
                col_d = '0;
                row_d = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
            end else begin
                col_d = col_eff + CW'(1);
                row_d = row_eff;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = line1_mem[col_eff];
            win_d[1][2] = line0_mem[col_eff];
            win_d[2][2] = bus.s_data;
        end
    end

    // Filter is evaluated on the window as it will look after this accept.
    always_comb begin
        sum = tap(win_d[0][0], K_CORNER) + tap(win_d[0][2], K_CORNER)
            + tap(win_d[2][0], K_CORNER) + tap(win_d[2][2], K_CORNER)
            + tap(win_d[0][1], K_EDGE)   + tap(win_d[1][0], K_EDGE)
            + tap(win_d[1][2], K_EDGE)   + tap(win_d[2][1], K_EDGE)
            + tap(win_d[1][1], K_CENTER);
        shifted = sum >>> DIV_SHIFT;
`ifdef FILTER3X3_ABS_EN
        mag = (shifted < 0) ? -shifted : shifted;
`else
        mag = (shifted < 0) ? '0 : shifted;
`endif
        result = (mag > MAX_PIX) ? MAX_PIX[PIX_W-1:0] : mag[PIX_W-1:0];
    end

    assign produce = accept && (row_eff == 2'd2) && (col_eff >= FIRST_OUT_COL);

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_eol_d   = m_eol_q;
        if (accept) begin
            m_valid_d = produce;
            if (produce) begin
                m_data_d = result;
                m_eol_d  = (col_eff == LAST_COL);
            end
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_eol_q   <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_eol_q   <= m_eol_d;
            win_q     <= win_d;
        end
    end

    // Line buffers are left unreset; the row counter keeps stale lines out of any result.
    always_ff @(posedge clk) begin
        if (accept) begin
            line0_mem[col_eff] <= bus.s_data;
            line1_mem[col_eff] <= line0_mem[col_eff];
        end
    end
endmodule

// File: tb/tb_filter_3x3_stream.sv
// Scoreboard bench for filter_3x3_stream: directed frames push expected results, a monitor pops on each output.
module tb_filter_3x3_stream;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    filter_3x3_stream_if #(.PIX_W(16)) bus ();
    filter_3x3_stream dut (.clk(clk), .reset(reset), .bus(bus));

    filter_3x3_stream_if #(.PIX_W(8)) bus2 ();
    filter_3x3_stream #(.LINE_LEN(4), .PIX_W(8), .W_CORNER(0), .W_EDGE(-1), .W_CENTER(8), .DIV_SHIFT(2))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] exp_q [$];
    bit chk_rowlen = 1'b0;
    int row_outs = 0;
    bit done;

`ifdef FILTER3X3_ABS_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pix_of(input int mode, input int r, input int c);
        case (mode)
            0:       return 100;
            1:       return (r == 5 && c == 5) ? 1000 : 0;
            2:       return ((r + c) % 2 == 0) ? 200 : 0;
            default: return 50;
        endcase
    endfunction

    // Expected filter output for the window centred at (r,c), default weights.
    function automatic int exp_of(input int mode, input int r, input int c);
        if (mode == 1) begin
            if ((r == 4 && c == 5) || (r == 6 && c == 5) || (r == 5 && c == 4) || (r == 5 && c == 6))
                return 1000;
            if (r == 5 && c == 5) return ABS ? 4000 : 0;
            return 0;
        end
        if (mode == 2) return ((r + c) % 2 == 1) ? 800 : (ABS ? 800 : 0);
        return 0;
    endfunction

    task automatic push(input int d, input bit sof, input bit ev, input int ed, input bit ee);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'(d);
        bus.s_sof   = sof;
        @(negedge clk);
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) chk("s_ready_timeout", 0, 1);
        if (ev) exp_q.push_back({16'(ed), ee});
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    task automatic run(input int mode, input int r0, input int c0, input int r1, input int c1);
        for (int r = r0; r <= r1; r++)
            for (int c = (r == r0 ? c0 : 0); c <= (r == r1 ? c1 : 239); c++)
                push(pix_of(mode, r, c), (r == 0 && c == 0), (r >= 2 && c >= 2),
                     exp_of(mode, r - 1, c - 1), (c == 239));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pending_expected", exp_q.size(), 0);
    endtask

    initial begin : monitor
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (reset && bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got data %0d, want no output (t=%0t)", bus.m_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", int'(bus.m_data), int'(e[16:1]));
                    chk("m_eol", int'(bus.m_eol), int'(e[0]));
                end
                row_outs++;
                if (bus.m_eol) begin
                    if (chk_rowlen) chk("outputs_per_row", row_outs, 238);
                    row_outs = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        bit found;
        reset = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_sof = 1'b0; bus.m_ready = 1'b1;
        bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.s_sof = 1'b0; bus2.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_eol", bus.m_eol, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Flat frame: all zero results, 238 per row.
        chk_rowlen = 1'b1;
        run(0, 0, 0, 3, 239);
        drain();

        // Impulse frame with a 3-cycle stall on the first non-zero output.
        found = 1'b0;
        fork
            run(1, 0, 0, 7, 239);
            begin
                n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                    found = bus.m_valid && (bus.m_data == 16'd1000);
                end while (!found && n < 5000);
                chk("stall_found", int'(found), 1);
                bus.m_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_s_ready", bus.s_ready, 0);
                    chk("stall_m_valid", bus.m_valid, 1);
                    chk("stall_m_data", bus.m_data, 1000);
                end
                @(posedge clk); #1;
                bus.m_ready = 1'b1;
            end
        join
        drain();

        // Flat frame under random backpressure: nothing lost or duplicated.
        done = 1'b0;
        fork
            begin
                run(3, 0, 0, 3, 239);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.m_ready = 1'($urandom_range(0, 1));
                end
                bus.m_ready = 1'b1;
            end
        join
        drain();
        chk_rowlen = 1'b0;

        // Reset mid-frame with an output pending, then a fresh checkerboard frame.
        run(3, 0, 0, 3, 100);
        bus.m_ready = 1'b0;
        chk("pre_reset_m_valid", bus.m_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_m_valid", bus.m_valid, 0);
        chk("async_rst_m_data", bus.m_data, 0);
        chk("async_rst_s_ready", bus.s_ready, 1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        run(2, 0, 0, 2, 239);
        drain();

        // SOF at row 4 column 57 restarts the frame; stale checkerboard must not leak.
        run(2, 0, 0, 4, 56);
        run(0, 0, 0, 2, 239);
        drain();

        // Sharpen configuration on a saturated frame: (8*255 - 4*255) >>> 2 = 255.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                bus2.s_valid = 1'b1;
                bus2.s_data  = 8'd255;
                bus2.s_sof   = (r == 0 && c == 0);
                @(posedge clk); #1;
                if (r >= 2 && c >= 2) begin
                    chk("cfg_m_valid", bus2.m_valid, 1);
                    chk("cfg_m_data", bus2.m_data, 255);
                    chk("cfg_m_eol", bus2.m_eol, (c == 3) ? 1 : 0);
                end else begin
                    chk("cfg_no_output", bus2.m_valid, 0);
                end
            end
        bus2.s_valid = 1'b0;
        bus2.s_sof   = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
